// File: rtl/ram_16x8_sync_wr_pkg.sv
// Shared definitions for the 16x8 writable memory: default geometry,
// fill-sequencer state encoding and the fill-pattern replication helper.
package ram_16x8_sync_wr_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    // FILL: sequencer owns the write port; READY: contents valid, user writes accepted
    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_READY = 1'b1
    } fill_state_e;

    // Number of address copies that make up one fill word (addr replicated to DATA_W)
    function automatic int fill_reps(input int addr_w, input int data_w);
        return data_w / addr_w;
    endfunction

endpackage

// File: rtl/ram_16x8_sync_wr_mem_fill_seq.sv
// Fill sequencer: walks every address once writing the replicated-address
// pattern, then sits in READY until a re-fill is requested.
module mem_fill_seq
    import ram_16x8_sync_wr_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int INIT_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_start,
    output logic              busy,
    output logic              init_done,
    output logic              fill_we,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data
);

    localparam int                REPS      = fill_reps(ADDR_W, DATA_W);
    localparam fill_state_e       RST_STATE = (INIT_EN != 0) ? ST_FILL : ST_READY;
    localparam logic [ADDR_W-1:0] CNT_ZERO  = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] CNT_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] CNT_LAST  = {ADDR_W{1'b1}};

    fill_state_e       r_state;
    fill_state_e       w_state_nxt;
    logic [ADDR_W-1:0] r_fill_cnt;
    logic [ADDR_W-1:0] w_fill_cnt_nxt;
    logic              r_busy;
    logic              r_init_done;

    // Next-state logic: count through all addresses in FILL, start a fresh fill from READY on request
    always_comb begin
        w_state_nxt    = r_state;
        w_fill_cnt_nxt = r_fill_cnt;
        case (r_state)
            ST_FILL: begin
                w_fill_cnt_nxt = r_fill_cnt + CNT_ONE;
                if (r_fill_cnt == CNT_LAST) begin
                    w_state_nxt = ST_READY;
                end else begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_READY: begin
                if (init_start) begin
                    w_state_nxt    = ST_FILL;
                    w_fill_cnt_nxt = CNT_ZERO;
                end else begin
                    w_state_nxt    = ST_READY;
                    w_fill_cnt_nxt = r_fill_cnt;
                end
            end
            default: begin
                w_state_nxt    = RST_STATE;
                w_fill_cnt_nxt = CNT_ZERO;
            end
        endcase
    end

    // State, counter and status flags; flags are decoded from the next state so they switch on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RST_STATE;
            r_fill_cnt  <= CNT_ZERO;
            r_busy      <= (INIT_EN != 0);
            r_init_done <= (INIT_EN == 0);
        end else begin
            r_state     <= w_state_nxt;
            r_fill_cnt  <= w_fill_cnt_nxt;
            r_busy      <= (w_state_nxt == ST_FILL);
            r_init_done <= (w_state_nxt == ST_READY);
        end
    end

    assign busy      = r_busy;
    assign init_done = r_init_done;
    assign fill_we   = (r_state == ST_FILL);
    assign fill_addr = r_fill_cnt;
    assign fill_data = {REPS{r_fill_cnt}};

endmodule

// File: rtl/ram_16x8_sync_wr.sv
// 16x8 memory with a synchronous write port, a combinational read port and a
// built-in fill sequencer that loads addr*0x11 after reset or on request.
module ram_16x8_sync_wr
    import ram_16x8_sync_wr_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int INIT_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_start,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              wr_err,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              init_done
);

    localparam int DEPTH = 1 << ADDR_W;

    logic              w_fill_we;
    logic [ADDR_W-1:0] w_fill_addr;
    logic [DATA_W-1:0] w_fill_data;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_wr_ack;
    logic              r_wr_err;

    mem_fill_seq #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .INIT_EN (INIT_EN)
    ) u_fill_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_start (init_start),
        .busy       (busy),
        .init_done  (init_done),
        .fill_we    (w_fill_we),
        .fill_addr  (w_fill_addr),
        .fill_data  (w_fill_data)
    );

    // Memory write port: the sequencer has priority; user writes are dropped while it runs or in reset
    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            r_mem[w_fill_addr] <= w_fill_data;
        end else if (we && rst_n) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // One-cycle write response: accepted when the sequencer is idle, rejected while it is filling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ack <= 1'b0;
            r_wr_err <= 1'b0;
        end else begin
            r_wr_ack <= we && !w_fill_we;
            r_wr_err <= we && w_fill_we;
        end
    end

    assign wr_ack  = r_wr_ack;
    assign wr_err  = r_wr_err;
    assign rd_data = r_mem[rd_addr];

endmodule
